// File: rtl/sr_flag_bank.sv
// N-channel clocked SR flag bank with rise/fall pulses, sticky conflict flags
// and a registered count of set flags.
module sr_flag_bank #(
  parameter int unsigned   N         = 8,
  parameter int unsigned   MODE      = 1,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [N-1:0]             s,
  input  logic [N-1:0]             r,
  input  logic [N-1:0]             clr_conflict,
  output logic [N-1:0]             q,
  output logic [N-1:0]             q_rise,
  output logic [N-1:0]             q_fall,
  output logic [N-1:0]             conflict,
  output logic [$clog2(N+1)-1:0]   set_count,
  output logic                     any_set
);

  localparam int unsigned CW = $clog2(N + 1);

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [N-1:0]  conflict_q, conflict_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        unique case ({s[i], r[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            case (MODE)
              1:       q_d[i] = 1'b1;
              2:       q_d[i] = 1'b0;
              3:       q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
    rise_d     = ~q_q & q_d;
    fall_d     = q_q & ~q_d;
    // A new conflict wins over a same-edge clear so the event is never lost.
    conflict_d = (conflict_q & ~clr_conflict) | (en ? (s & r) : '0);
    count_d    = popcount(q_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= RESET_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= '0;
      count_q    <= popcount(RESET_VAL);
    end else begin
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign q         = q_q;
  assign q_rise    = rise_q;
  assign q_fall    = fall_q;
  assign conflict  = conflict_q;
  assign set_count = count_q;
  assign any_set   = |q_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: main MODE=1 instance plus MODE 0/2/3 instances.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] s, r, clr;

  logic [7:0] q1, rise1, fall1, conf1;
  logic [3:0] cnt1;
  logic       any1;
  logic [7:0] q0, rise0, fall0, conf0;
  logic [3:0] cnt0;
  logic       any0;
  logic [7:0] q2, rise2, fall2, conf2;
  logic [3:0] cnt2;
  logic       any2;
  logic [7:0] q3, rise3, fall3, conf3;
  logic [3:0] cnt3;
  logic       any3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_flag_bank #(.N(8), .MODE(1), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_conflict(clr),
    .q(q1), .q_rise(rise1), .q_fall(fall1), .conflict(conf1),
    .set_count(cnt1), .any_set(any1));

  sr_flag_bank #(.N(8), .MODE(0), .RESET_VAL(8'h00)) u_m0 (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_conflict(clr),
    .q(q0), .q_rise(rise0), .q_fall(fall0), .conflict(conf0),
    .set_count(cnt0), .any_set(any0));

  sr_flag_bank #(.N(8), .MODE(2), .RESET_VAL(8'h00)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_conflict(clr),
    .q(q2), .q_rise(rise2), .q_fall(fall2), .conflict(conf2),
    .set_count(cnt2), .any_set(any2));

  sr_flag_bank #(.N(8), .MODE(3), .RESET_VAL(8'h00)) u_m3 (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_conflict(clr),
    .q(q3), .q_rise(rise3), .q_fall(fall3), .conflict(conf3),
    .set_count(cnt3), .any_set(any3));

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s = '0; r = '0; clr = '0; en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // state before the async reset: q=A5, conflict on bit 0
    en = 1'b1; s = 8'hA5; r = 8'h01; clr = '0;
    edge_step();
    s = '0; r = '0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (q1 !== 8'h00 || conf1 !== 8'h00 || cnt1 !== 4'd0 || any1 !== 1'b0 ||
        rise1 !== 8'h00 || fall1 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: q=%h conf=%h cnt=%0d any=%b rise=%h fall=%h, want all 0",
               q1, conf1, cnt1, any1, rise1, fall1);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_set_reset();
    en = 1'b1; s = 8'h0F; r = '0;
    edge_step();
    vectors++;
    if (q1 !== 8'h0F || rise1 !== 8'h0F || fall1 !== 8'h00 || cnt1 !== 4'd4 || any1 !== 1'b1) begin
      miscompares++;
      $display("FAIL set_0F: q=%h rise=%h fall=%h cnt=%0d any=%b, want 0f 0f 00 4 1",
               q1, rise1, fall1, cnt1, any1);
    end
    s = '0;
    edge_step();
    vectors++;
    if (q1 !== 8'h0F || rise1 !== 8'h00) begin
      miscompares++;
      $display("FAIL rise_one_cycle: q=%h rise=%h, want 0f 00", q1, rise1);
    end
    r = 8'h03;
    edge_step();
    vectors++;
    if (q1 !== 8'h0C || fall1 !== 8'h03 || rise1 !== 8'h00 || cnt1 !== 4'd2) begin
      miscompares++;
      $display("FAIL reset_03: q=%h fall=%h rise=%h cnt=%0d, want 0c 03 00 2",
               q1, fall1, rise1, cnt1);
    end
    r = '0;
    edge_step();
    vectors++;
    if (q1 !== 8'h0C || fall1 !== 8'h00) begin
      miscompares++;
      $display("FAIL fall_one_cycle: q=%h fall=%h, want 0c 00", q1, fall1);
    end
  endtask

  task automatic test_enable();
    en = 1'b0; s = 8'hFF; r = '0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      vectors++;
      if (q1 !== 8'h0C || rise1 !== 8'h00 || conf1 !== 8'h00 || cnt1 !== 4'd2) begin
        miscompares++;
        $display("FAIL en0_hold[%0d]: q=%h rise=%h conf=%h cnt=%0d, want 0c 00 00 2",
                 i, q1, rise1, conf1, cnt1);
      end
    end
    en = 1'b1;
    edge_step();
    vectors++;
    if (q1 !== 8'hFF || rise1 !== 8'hF3 || cnt1 !== 4'd8 || fall1 !== 8'h00) begin
      miscompares++;
      $display("FAIL en1_set_all: q=%h rise=%h cnt=%0d fall=%h, want ff f3 8 00",
               q1, rise1, cnt1, fall1);
    end
    // set-while-set: no pulse, and en=0 with s=r=1 records no conflict
    en = 1'b0; r = 8'hFF;
    edge_step();
    vectors++;
    if (q1 !== 8'hFF || rise1 !== 8'h00 || conf1 !== 8'h00 || cnt1 !== 4'd8) begin
      miscompares++;
      $display("FAIL en0_no_conflict: q=%h rise=%h conf=%h cnt=%0d, want ff 00 00 8",
               q1, rise1, conf1, cnt1);
    end
    en = 1'b1; r = '0;
  endtask

  task automatic test_mode_sweep();
    do_reset();
    en = 1'b1; s = 8'h01; r = 8'h01;
    edge_step();
    vectors++;
    if (q0 !== 8'h00 || q1 !== 8'h01 || q2 !== 8'h00 || q3 !== 8'h01 || rise3 !== 8'h01) begin
      miscompares++;
      $display("FAIL mode_edge1: q0=%h q1=%h q2=%h q3=%h rise3=%h, want 00 01 00 01 01",
               q0, q1, q2, q3, rise3);
    end
    vectors++;
    if (conf0 !== 8'h01 || conf1 !== 8'h01 || conf2 !== 8'h01 || conf3 !== 8'h01) begin
      miscompares++;
      $display("FAIL mode_conflict: c0=%h c1=%h c2=%h c3=%h, want 01 each",
               conf0, conf1, conf2, conf3);
    end
    edge_step();
    vectors++;
    if (q0 !== 8'h00 || q1 !== 8'h01 || q2 !== 8'h00 || q3 !== 8'h00 ||
        fall3 !== 8'h01 || rise3 !== 8'h00 || rise1 !== 8'h00) begin
      miscompares++;
      $display("FAIL mode_edge2: q0=%h q1=%h q2=%h q3=%h fall3=%h rise3=%h rise1=%h, want 00 01 00 00 01 00 00",
               q0, q1, q2, q3, fall3, rise3, rise1);
    end
    s = '0; r = '0;
  endtask

  task automatic test_conflict_clear();
    do_reset();
    s = 8'h04; r = 8'h04;
    edge_step();
    vectors++;
    if (conf1 !== 8'h04 || q1 !== 8'h04) begin
      miscompares++;
      $display("FAIL conflict_set: conf=%h q=%h, want 04 04", conf1, q1);
    end
    s = '0; r = '0; clr = 8'h04;
    edge_step();
    vectors++;
    if (conf1 !== 8'h00) begin
      miscompares++;
      $display("FAIL conflict_clear: conf=%h, want 00", conf1);
    end
    s = 8'h04; r = 8'h04; clr = 8'h04;
    edge_step();
    vectors++;
    if (conf1 !== 8'h04) begin
      miscompares++;
      $display("FAIL conflict_clear_race: conf=%h, want 04", conf1);
    end
    s = '0; r = '0; clr = '0;
    edge_step();
    vectors++;
    if (conf1 !== 8'h04) begin
      miscompares++;
      $display("FAIL conflict_sticky: conf=%h, want 04", conf1);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    s = 8'h80;
    edge_step();
    vectors++;
    if (rise1 !== 8'h80 || q1 !== 8'h80 || cnt1 !== 4'd1) begin
      miscompares++;
      $display("FAIL pulse_before_reset: rise=%h q=%h cnt=%0d, want 80 80 1", rise1, q1, cnt1);
    end
    s = '0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (rise1 !== 8'h00 || q1 !== 8'h00 || cnt1 !== 4'd0 || any1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: rise=%h q=%h cnt=%0d any=%b, want 00 00 0 0",
               rise1, q1, cnt1, any1);
    end
    @(negedge clk);
    reset = 1'b0;
    edge_step();
    vectors++;
    if (rise1 !== 8'h00 || fall1 !== 8'h00 || q1 !== 8'h00) begin
      miscompares++;
      $display("FAIL post_reset_edge: rise=%h fall=%h q=%h, want 00 00 00", rise1, fall1, q1);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; s = '0; r = '0; clr = '0;
    #1;
    vectors++;
    if (q1 !== 8'h00 || cnt1 !== 4'd0 || conf1 !== 8'h00 || any1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_initial: q=%h cnt=%0d conf=%h any=%b, want 00 0 00 0",
               q1, cnt1, conf1, any1);
    end
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_set_reset();
    test_enable();
    test_mode_sweep();
    test_conflict_clear();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
